// File: rtl/adder_multicycle.sv
// Multi-cycle adder/subtractor. Each cycle it processes SLICE bits and passes the carry
// to the next slice through a register. Uses a start/busy/done handshake and produces
// carry, signed-overflow and zero flags.
module adder_multicycle #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             Co,
    output logic             Ov,
    output logic             Zf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int SUM_W  = SLICE + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, f_q;
    logic             carry_q, busy_q, done_q, co_q, ov_q, zf_q;

    logic [SUM_W-1:0] slice_sum;
    logic             last_slice;
    logic [WIDTH-1:0] acc_d;
    logic             ov_d;
    logic             zf_d;

    // The operands shift right one slice per cycle, so the active slice is always the low
    // SLICE bits. The accumulator fills from the top, so after the last slice the result is in order.
    always_comb begin
        slice_sum  = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + SUM_W'(carry_q);
        last_slice = (idx_q == IDX_W'(NSLICE - 1));
        acc_d      = (acc_q >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
        // a ^ b ^ sum at the MSB gives the carry into the MSB.
        ov_d       = (a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_sum[SLICE-1]) ^ slice_sum[SLICE];
        zf_d       = ~|acc_d;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values;
    // the async reset clears the datapath registers too, leaving no stale operands after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            f_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
            zf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        a_q     <= A;
                        b_q     <= sub ? ~B : B;
                        carry_q <= Ci ^ sub;
                        idx_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    acc_q   <= acc_d;
                    carry_q <= slice_sum[SLICE];
                    idx_q   <= idx_q + 1'b1;
                    if (last_slice) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        f_q     <= acc_d;
                        co_q    <= slice_sum[SLICE];
                        ov_q    <= ov_d;
                        zf_q    <= zf_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign F    = f_q;
    assign Co   = co_q;
    assign Ov   = ov_q;
    assign Zf   = zf_q;

endmodule

// File: tb/tb_adder_multicycle.sv
// Directed bench for adder_multicycle: an 8-bit / 4-bit-slice instance and a 1-bit instance
// that is checked against the full-adder truth table.
module tb_adder_multicycle;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8-bit instance, two slices
    logic       start8, sub8, ci8;
    logic [7:0] a8, b8, f8;
    logic       busy8, done8, co8, ov8, zf8;

    adder_multicycle #(.WIDTH(8), .SLICE(4)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .A(a8), .B(b8), .Ci(ci8),
        .busy(busy8), .done(done8), .F(f8), .Co(co8), .Ov(ov8), .Zf(zf8)
    );

    // 1-bit instance, single slice
    logic       start1, sub1, ci1;
    logic [0:0] a1, b1, f1;
    logic       busy1, done1, co1, ov1, zf1;

    adder_multicycle #(.WIDTH(1), .SLICE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1), .A(a1), .B(b1), .Ci(ci1),
        .busy(busy1), .done(done1), .F(f1), .Co(co1), .Ov(ov1), .Zf(zf1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one op on the 8-bit instance, counts busy cycles up to done, then checks the result.
    task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic sb, input logic [7:0] exp_f,
                           input logic exp_co, input logic exp_ov, input logic exp_zf);
        int busy_cycles;
        @(negedge clk);
        a8 = a; b8 = b; ci8 = ci; sub8 = sb; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; ci8 = ~ci; sub8 = ~sb;   // operands may change after the start edge
        busy_cycles = 0;
        while (!done8 && busy_cycles < 10) begin
            if (busy8) busy_cycles++;
            @(negedge clk);
        end
        check({tag, "_done"}, done8, 1);
        check({tag, "_busy_cycles"}, busy_cycles, 2);
        check({tag, "_busy_at_done"}, busy8, 0);
        check({tag, "_F"}, f8, exp_f);
        check({tag, "_Co"}, co8, exp_co);
        check({tag, "_Ov"}, ov8, exp_ov);
        check({tag, "_Zf"}, zf8, exp_zf);
        @(negedge clk);
        check({tag, "_done_pulse"}, done8, 0);
        check({tag, "_F_held"}, f8, exp_f);
    endtask

    task automatic run_op1(input string tag, input logic a, input logic b, input logic ci,
                           input logic [1:0] exp_cf);
        int waited;
        @(negedge clk);
        a1 = a; b1 = b; ci1 = ci; sub1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check({tag, "_busy"}, busy1, 1);
        waited = 0;
        while (!done1 && waited < 10) begin
            waited++;
            @(negedge clk);
        end
        check({tag, "_latency"}, waited, 1);
        check({tag, "_CoF"}, {co1, f1}, exp_cf);
    endtask

    int t_done1;
    int gap_busy;
    int saw_done;

    initial begin
        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; ci8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; sub1 = 1'b0; ci1 = 1'b0; a1 = '0; b1 = '0;

        // 1. reset held while start is asserted
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_F", f8, 8'h00);
        check("rst_flags", {co8, ov8, zf8}, 3'b000);
        start8 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", busy8, 0);

        // 2-4. arithmetic vectors
        run_op8("ff_plus_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op8("7f_plus_ci",  8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op8("80_plus_ff",  8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op8("05_minus_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op8("80_minus_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op8("10_minus_0f", 8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

        // 5a. a start one cycle into a run is ignored
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        check("ign_busy", busy8, 1);
        @(negedge clk);
        check("ign_done", done8, 1);
        check("ign_F", f8, 8'h46);
        @(negedge clk);
        check("ign_no_second_done", done8, 0);
        check("ign_idle", busy8, 0);
        check("ign_F_held", f8, 8'h46);

        // 5b. start held through the done cycle: the done cycle is IDLE and accepts the next op
        @(negedge clk);
        a8 = 8'h20; b8 = 8'h03; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h05;
        @(negedge clk);
        @(negedge clk);
        check("b2b_done1", done8, 1);
        check("b2b_F1", f8, 8'h23);
        t_done1 = cyc;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_accepted", busy8, 1);
        gap_busy = 0;
        while (!done8 && gap_busy < 10) begin
            gap_busy++;
            @(negedge clk);
        end
        check("b2b_done2", done8, 1);
        check("b2b_F2", f8, 8'h45);
        // NSLICE busy cycles after the accepting done cycle
        check("b2b_period", cyc - t_done1, 3);

        // 6. reset mid-run: operation lost, outputs cleared at once
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("abort_busy_before", busy8, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy8, 0);
        check("abort_F", f8, 8'h00);
        check("abort_flags", {done8, co8, ov8, zf8}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (4) begin
            @(negedge clk);
            if (done8) saw_done++;
        end
        check("abort_no_done", saw_done, 0);
        run_op8("after_abort", 8'h21, 8'h12, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

        // 7. 1-bit instance: full-adder truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_op1($sformatf("fa_%0d", i), v[2], v[1], v[0],
                    2'(32'(v[2]) + 32'(v[1]) + 32'(v[0])));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
